// File: rtl/seq1100111_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first rep_count times, with an
// optional fill gap between repetitions. This is the driving end for a 1100111 detector.
module seq1100111_tx #(
  parameter int                 PAT_W   = 7,
  parameter logic [PAT_W-1:0]   PATTERN = 7'b1100111,
  parameter int                 CNT_W   = 8,
  parameter int                 GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_count,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             gap_fill,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             seq_end,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             gap_fill_q, gap_fill_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             seq_end_q, seq_end_d;
  logic             done_q, done_d;

  // Outputs are a registered view of the state being left at each edge.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    rep_d       = rep_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    gap_fill_d  = gap_fill_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    seq_end_d   = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          rep_d      = rep_count;
          gap_len_d  = gap_len;
          gap_fill_d = gap_fill;
          bit_idx_d  = TOP_IDX;
          state_d    = (rep_count != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        out_d       = PATTERN[bit_idx_q];
        out_valid_d = 1'b1;
        if (bit_idx_q == '0) begin
          seq_end_d = 1'b1;
          bit_idx_d = TOP_IDX;
          if (rep_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            rep_d = rep_q - CNT_W'(1);
            if (gap_len_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q - GAP_W'(1);
            end
          end
        end else begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end
      GAP: begin
        out_d       = gap_fill_q;
        out_valid_d = 1'b1;
        if (gap_cnt_q == '0) state_d = SEND;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including the pending done pulse.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      seq_end_d   = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      rep_q       <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      gap_fill_q  <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      seq_end_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      rep_q       <= rep_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_fill_q  <= gap_fill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      seq_end_q   <= seq_end_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign seq_end   = seq_end_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq1100111_tx.sv
// Bench for seq1100111_tx: a queue of expected per-edge outputs is built from
// each accepted frame and popped one entry per clock.
module tb_seq1100111_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rep_count;
  logic [3:0] gap_len;
  logic       gap_fill;
  logic       abort;
  logic       dout, out_valid, busy, seq_end, done;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] PAT = 7'b1100111;

  typedef struct packed {
    logic o;
    logic v;
    logic se;
    logic dn;
    logic bz;
  } exp_t;

  exp_t mq[$];

  seq1100111_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rep_count (rep_count),
    .gap_len   (gap_len),
    .gap_fill  (gap_fill),
    .abort     (abort),
    .out       (dout),
    .out_valid (out_valid),
    .busy      (busy),
    .seq_end   (seq_end),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out"},       32'(dout),      32'(e.o));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
    chk({tag, ".seq_end"},   32'(seq_end),   32'(e.se));
    chk({tag, ".done"},      32'(done),      32'(e.dn));
    chk({tag, ".busy"},      32'(busy),      32'(e.bz));
  endtask

  // Whole frame: rc patterns MSB-first, gl fill cycles between them, then done.
  task automatic build(input logic [7:0] rc, input logic [3:0] gl, input logic gf);
    for (int r = 0; r < int'(rc); r++) begin
      for (int b = 6; b >= 0; b--) mq.push_back('{PAT[b], 1'b1, (b == 0), 1'b0, 1'b1});
      if (r != int'(rc) - 1)
        for (int g = 0; g < int'(gl); g++) mq.push_back('{gf, 1'b1, 1'b0, 1'b0, 1'b1});
    end
    mq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic step(input string tag, input logic s, input logic [7:0] rc,
                      input logic [3:0] gl, input logic gf, input logic ab);
    exp_t e;
    @(negedge clk);
    start = s; rep_count = rc; gap_len = gl; gap_fill = gf; abort = ab;
    e = '0;
    if (mq.size() != 0) begin
      if (ab) mq.delete();
      else    e = mq.pop_front();
    end else if (s) begin
      build(rc, gl, gf);
    end
    @(posedge clk);
    #1;
    chk_all(tag, e);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (mq.size() != 0 && budget < 6000) begin
      step(tag, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
      budget++;
    end
    chk({tag, ".drain_timeout"}, 32'(mq.size()), 32'd0);
    idle(tag, 2);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rep_count = '0; gap_len = '0; gap_fill = 1'b0; abort = 1'b0;
    #12;
    chk_all("reset", '0);
    @(negedge clk);
    rst = 1'b1;
    idle("post_reset", 2);

    step("single", 1'b1, 8'd1, 4'd0, 1'b0, 1'b0);
    idle("single", 10);

    step("b2b", 1'b1, 8'd2, 4'd0, 1'b1, 1'b0);
    idle("b2b", 17);

    step("gap", 1'b1, 8'd2, 4'd3, 1'b0, 1'b0);
    idle("gap", 20);

    step("gap_fill1", 1'b1, 8'd3, 4'd2, 1'b1, 1'b0);
    drain("gap_fill1");

    step("abort", 1'b1, 8'd3, 4'd0, 1'b0, 1'b0);
    idle("abort", 3);
    step("abort_hit", 1'b0, 8'd0, 4'd0, 1'b0, 1'b1);
    idle("abort_after", 25);

    // Start pulsed mid-frame with different settings must be ignored.
    step("ign_start", 1'b1, 8'd2, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("ign_start_mid", 1'b1, 8'd5, 4'd7, 1'b0, 1'b0);
    drain("ign_start");

    step("zero_cnt", 1'b1, 8'd0, 4'd5, 1'b1, 1'b0);
    idle("zero_cnt", 3);

    step("start_abort_idle", 1'b1, 8'd1, 4'd0, 1'b0, 1'b1);
    drain("start_abort_idle");

    step("abort_done", 1'b1, 8'd1, 4'd0, 1'b0, 1'b0);
    idle("abort_done", 7);
    step("abort_done_hit", 1'b0, 8'd0, 4'd0, 1'b0, 1'b1);
    idle("abort_done_after", 3);

    step("max", 1'b1, 8'd255, 4'd15, 1'b1, 1'b0);
    drain("max");

    // Asynchronous reset in the middle of a frame.
    step("rst_mid", 1'b1, 8'd2, 4'd1, 1'b1, 1'b0);
    idle("rst_mid", 4);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_all("rst_mid_async", '0);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    idle("rst_release", 12);

    for (int i = 0; i < 1500; i++) begin
      logic s, ab;
      logic [7:0] rc;
      s  = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 40) == 0);
      rc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3));
      step("rand", s, rc, 4'($urandom_range(0, 15)), 1'($urandom), ab);
    end
    drain("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
